// File: rtl/masked_share_encoder_if.sv
// masked_share_encoder_if: request, PRNG and result handshakes of the share encoder.
interface masked_share_encoder_if #(
    parameter int D     = 2,
    parameter int W     = 5,
    parameter int RND_W = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode;
    logic [(D+1)*W-1:0]   in_data;
    logic                 rnd_valid;
    logic                 rnd_ready;
    logic [RND_W-1:0]     rnd_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [(D+1)*W-1:0]   out_shares;
    logic                 busy;

    modport slave (
        input  in_valid, in_mode, in_data, rnd_valid, rnd_data, out_ready,
        output in_ready, rnd_ready, out_valid, out_shares, busy
    );

    modport master (
        output in_valid, in_mode, in_data, rnd_valid, rnd_data, out_ready,
        input  in_ready, rnd_ready, out_valid, out_shares, busy
    );
endinterface

// File: rtl/masked_share_encoder.sv
// masked_share_encoder: gathers PRNG beats and emits D+1 Boolean shares (fresh or refreshed).
// Refresh mode exists only when SHARE_REFRESH_EN is defined; otherwise in_mode is ignored.
module masked_share_encoder #(
    parameter int D     = 2,
    parameter int W     = 5,
    parameter int RND_W = 5
) (
    input logic                   clk,
    input logic                   rst,
    masked_share_encoder_if.slave bus
);
    localparam int N_BEATS = (D*W + RND_W - 1) / RND_W;
    localparam int BUF_W   = N_BEATS * RND_W;
    localparam int CW      = N_BEATS > 1 ? $clog2(N_BEATS) : 1;
    localparam int SW      = (D+1) * W;
`ifdef SHARE_REFRESH_EN
    localparam int DW      = SW;
`else
    localparam int DW      = W;
`endif

    typedef enum logic [1:0] {IDLE, COLLECT, OUT} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [BUF_W-1:0]  r_buf;
    logic [DW-1:0]     r_data;
    logic [SW-1:0]     r_out;
    logic              r_in_ready;
    logic              r_rnd_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic [BUF_W-1:0]  w_buf;
    logic [W-1:0]      w_xor;
    logic [SW-1:0]     w_shares;

`ifdef SHARE_REFRESH_EN
    logic              r_mode;
`else
    logic              w_unused;
    assign w_unused = ^{bus.in_mode, bus.in_data};
`endif

    // Shares are built from the buffer with the current beat already merged in,
    // so the final beat lands in out_shares on the same edge it is consumed.
    always_comb begin
        w_buf = r_buf;
        w_buf[r_cnt*RND_W +: RND_W] = bus.rnd_data;
        w_xor = '0;
        w_shares = '0;
        for (int j = 0; j < D; j++) begin
            w_xor = w_xor ^ w_buf[j*W +: W];
`ifdef SHARE_REFRESH_EN
            w_shares[(j+1)*W +: W] = w_buf[j*W +: W] ^ (r_mode ? r_data[(j+1)*W +: W] : '0);
`else
            w_shares[(j+1)*W +: W] = w_buf[j*W +: W];
`endif
        end
        w_shares[W-1:0] = r_data[W-1:0] ^ w_xor;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_data      <= '0;
            r_out       <= '0;
            r_in_ready  <= 1'b1;
            r_rnd_ready <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SHARE_REFRESH_EN
            r_mode      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_data      <= bus.in_data[DW-1:0];
`ifdef SHARE_REFRESH_EN
                    r_mode      <= bus.in_mode;
`endif
                    r_cnt       <= '0;
                    r_state     <= COLLECT;
                    r_in_ready  <= 1'b0;
                    r_rnd_ready <= 1'b1;
                    r_busy      <= 1'b1;
                end
                COLLECT: if (bus.rnd_valid) begin
                    r_buf <= w_buf;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N_BEATS-1)) begin
                        r_out       <= w_shares;
                        r_state     <= OUT;
                        r_rnd_ready <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                OUT: if (bus.out_ready) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.rnd_ready  = r_rnd_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_shares = r_out;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_masked_share_encoder.sv
// tb_masked_share_encoder: directed checks of sharing, refresh, stalls, backpressure, partial beats, reset.
module tb_masked_share_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    masked_share_encoder_if #(.D(2), .W(5), .RND_W(5)) bus ();
    masked_share_encoder_if #(.D(2), .W(5), .RND_W(4)) b4 ();

    masked_share_encoder #(.D(2), .W(5), .RND_W(5)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    masked_share_encoder #(.D(2), .W(5), .RND_W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        tests++; if (bus.rnd_ready !== 1'b0) begin fails++; $display("FAIL reset_rnd_ready: got %b want 0", bus.rnd_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        tests++; if (bus.out_shares !== 15'h0) begin fails++; $display("FAIL reset_out_shares: got %h want 0000", bus.out_shares); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_share();
        bus.in_valid = 1'b1; bus.in_mode = 1'b0; bus.in_data = 15'h0016;
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.rnd_ready !== 1'b1) begin fails++; $display("FAIL share_collect_flags: got in_ready=%b busy=%b rnd_ready=%b want 0 1 1", bus.in_ready, bus.busy, bus.rnd_ready); end
        bus.rnd_valid = 1'b1; bus.rnd_data = 5'h0A;
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL share_early_valid: got %b want 0", bus.out_valid); end
        bus.rnd_data = 5'h13;
        step();
        bus.rnd_valid = 1'b0;
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL share_valid_t3: got %b want 1", bus.out_valid); end
        tests++; if (bus.out_shares !== 15'h4D4F) begin fails++; $display("FAIL share_result: got %h want 4d4f", bus.out_shares); end
        tests++; if (bus.rnd_ready !== 1'b0) begin fails++; $display("FAIL share_rnd_ready_out: got %b want 0", bus.rnd_ready); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL share_handshake: got out_valid=%b in_ready=%b busy=%b want 0 1 0", bus.out_valid, bus.in_ready, bus.busy); end
        tests++; if (bus.out_shares !== 15'h4D4F) begin fails++; $display("FAIL share_hold_after: got %h want 4d4f", bus.out_shares); end
    endtask

    task automatic test_refresh();
        logic [14:0] exp_sh;
        logic [4:0]  exp_x;
        logic [14:0] got;
`ifdef SHARE_REFRESH_EN
        exp_sh = 15'h491D; exp_x = 5'h07;
`else
        exp_sh = 15'h4D5D; exp_x = 5'h04;
`endif
        bus.in_valid = 1'b1; bus.in_mode = 1'b1; bus.in_data = {5'h01, 5'h02, 5'h04};
        step();
        bus.in_valid = 1'b0; bus.in_mode = 1'b0;
        bus.rnd_valid = 1'b1; bus.rnd_data = 5'h0A;
        step();
        bus.rnd_data = 5'h13;
        step();
        bus.rnd_valid = 1'b0;
        got = bus.out_shares;
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL refresh_valid: got %b want 1", bus.out_valid); end
        tests++; if (got !== exp_sh) begin fails++; $display("FAIL refresh_result: got %h want %h", got, exp_sh); end
        tests++; if ((got[14:10] ^ got[9:5] ^ got[4:0]) !== exp_x) begin fails++; $display("FAIL refresh_xor: got %h want %h", got[14:10] ^ got[9:5] ^ got[4:0], exp_x); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stall();
        bus.in_valid = 1'b1; bus.in_data = 15'h0000;
        step();
        bus.in_valid = 1'b0;
        bus.rnd_valid = 1'b1; bus.rnd_data = 5'h0A;
        step();
        bus.rnd_valid = 1'b0; bus.rnd_data = 5'h1F;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (bus.rnd_ready !== 1'b1 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL stall_cycle%0d: got rnd_ready=%b out_valid=%b want 1 0", i, bus.rnd_ready, bus.out_valid); end
        end
        bus.rnd_valid = 1'b1; bus.rnd_data = 5'h13;
        step();
        bus.rnd_valid = 1'b0;
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL stall_valid_t6: got %b want 1", bus.out_valid); end
        tests++; if (bus.out_shares !== 15'h4D59) begin fails++; $display("FAIL stall_result: got %h want 4d59", bus.out_shares); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.in_valid = 1'b1; bus.in_data = 15'h0016;
        step();
        bus.in_data = 15'h001F;
        bus.rnd_valid = 1'b1; bus.rnd_data = 5'h1F;
        step();
        bus.rnd_data = 5'h00;
        step();
        bus.rnd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (bus.out_valid !== 1'b1 || bus.out_shares !== 15'h03E9 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL bp_hold%0d: got out_valid=%b shares=%h in_ready=%b busy=%b want 1 03e9 0 1", i, bus.out_valid, bus.out_shares, bus.in_ready, bus.busy); end
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_partial();
        b4.in_valid = 1'b1; b4.in_data = 15'h0016;
        step();
        b4.in_valid = 1'b0;
        b4.rnd_valid = 1'b1; b4.rnd_data = 4'hA;
        step();
        b4.rnd_data = 4'h3;
        step();
        tests++; if (b4.out_valid !== 1'b0) begin fails++; $display("FAIL partial_early_valid: got %b want 0", b4.out_valid); end
        b4.rnd_data = 4'hF;
        step();
        b4.rnd_valid = 1'b0;
        tests++; if (b4.out_valid !== 1'b1) begin fails++; $display("FAIL partial_valid: got %b want 1", b4.out_valid); end
        tests++; if (b4.out_shares !== 15'h6755) begin fails++; $display("FAIL partial_result: got %h want 6755", b4.out_shares); end
        b4.out_ready = 1'b1;
        step();
        b4.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1; bus.in_data = 15'h0016;
        step();
        bus.in_valid = 1'b0;
        bus.rnd_valid = 1'b1; bus.rnd_data = 5'h05;
        step();
        rst = 1'b1;
        bus.rnd_data = 5'h1C;
        step();
        rst = 1'b0;
        bus.rnd_valid = 1'b0;
        tests++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rnd_ready !== 1'b0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_flags: got in_ready=%b busy=%b rnd_ready=%b out_valid=%b want 1 0 0 0", bus.in_ready, bus.busy, bus.rnd_ready, bus.out_valid); end
        tests++; if (bus.out_shares !== 15'h0) begin fails++; $display("FAIL rstmid_shares: got %h want 0000", bus.out_shares); end
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.rnd_valid = 1'b1; bus.rnd_data = 5'h0A;
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_one_beat: got %b want 0", bus.out_valid); end
        bus.rnd_data = 5'h13;
        step();
        bus.rnd_valid = 1'b0;
        tests++; if (bus.out_valid !== 1'b1 || bus.out_shares !== 15'h4D4F) begin fails++; $display("FAIL rstmid_result: got valid=%b shares=%h want 1 4d4f", bus.out_valid, bus.out_shares); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_data = '0;
        bus.rnd_valid = 1'b0; bus.rnd_data = '0; bus.out_ready = 1'b0;
        b4.in_valid = 1'b0; b4.in_mode = 1'b0; b4.in_data = '0;
        b4.rnd_valid = 1'b0; b4.rnd_data = '0; b4.out_ready = 1'b0;
        test_reset();
        test_share();
        test_refresh();
        test_stall();
        test_backpressure();
        test_partial();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/masked_share_encoder.md
Name: masked_share_encoder

Overview:
- Sequential, handshaked successor to the combinational share creator.
- Turns a W-bit unmasked value into D+1 Boolean shares, or, in refresh mode, re-masks an existing (D+1)-share input.
- Randomness comes from an external PRNG stream of RND_W bits per beat, gathered over several cycles.
- Sits between the Ascon datapath input and the masked permutation core.

Parameters:
- D, 2, masking order (D+1 shares); D >= 1.
- W, 5, bits per share (COL_SIZE*PAR in the core).
- RND_W, 5, PRNG beat width; N_BEATS = ceil(D*W/RND_W) is derived.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_mode  input  1  0 = fresh sharing, 1 = refresh
- in_data  input  (D+1)*W  share mode uses [W-1:0] only; refresh mode supplies share i at [i*W +: W]
- rnd_valid  input  1  PRNG beat valid
- rnd_ready  output  1  block consumes beat
- rnd_data  input  RND_W  random bits
- out_valid  output  1  shares valid
- out_ready  input  1  downstream accepts
- out_shares  output  (D+1)*W  share i at [i*W +: W]; share 0 is the corrective share
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, rnd_ready=0, out_valid=0, out_shares=0, busy=0, beat counter=0, mask buffer=0.
- FSM: IDLE -> COLLECT -> OUT -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data and in_mode, clear beat counter, go to COLLECT.
- COLLECT:
  - in_ready=0, rnd_ready=1.
  - On each rnd_valid: write rnd_data into the mask buffer at [cnt*RND_W], then increment cnt.
  - On the last beat (cnt == N_BEATS-1), register the result into out_shares and go to OUT.
  - rnd_valid low: counter and buffer hold; there is no timeout.
  - Bits of the final beat beyond D*W are discarded.
- OUT:
  - out_valid=1; out_shares stay stable until out_ready.
  - On out_ready: go to IDLE. out_valid drops next cycle and in_ready rises next cycle (no skid).
- Masks: r_j = buffer[j*W +: W] for j = 0..D-1.
- Share mode:
  - share j+1 = r_j.
  - share 0 = in_data[W-1:0] XOR all r_j.
- Refresh mode:
  - share j+1 = in_j+1 XOR r_j.
  - share 0 = in_0 XOR all r_j.
  - The XOR of all output shares equals the XOR of all input shares.
- Latency: request accepted at cycle t. With beats arriving back to back, out_valid is high at t+N_BEATS+1. Throughput is one result per N_BEATS+2 cycles minimum.
- out_shares keeps its last value after the handshake until the next result is loaded. Only reset clears it.
- Reset in any state returns to IDLE and discards the request and any partial randomness. A PRNG beat presented in the reset cycle is not consumed (rnd_ready=0 after reset).
- rnd_ready is never high outside COLLECT. in_valid during COLLECT or OUT is ignored.

Optional Feature:
- Macro SHARE_REFRESH_EN.
- Defined: in_mode selects refresh as described above.
- Undefined:
  - in_mode is ignored and treated as 0.
  - in_data bits above W-1 are unused.
  - The refresh XOR logic is not synthesised.
- Port list is identical in both builds.

Test Plan:
- Share, D=2 W=5 RND_W=5: in_data[4:0]=0x16, beats 0x0A then 0x13 -> out_shares=0x4D4F ({0x13,0x0A,0x0F}); out_valid at t+3.
- Refresh (SHARE_REFRESH_EN): in_data={0x01,0x02,0x04}, beats 0x0A,0x13 -> out_shares={0x12,0x08,0x1D}; XOR of shares is 0x07 on both sides.
- PRNG stall: rnd_valid low 3 cycles between the two beats -> second beat written correctly; out_valid at t+6; rnd_ready high throughout COLLECT.
- Backpressure: out_ready low 4 cycles -> out_shares and out_valid stable, in_ready=0, busy=1; handshake in cycle 5 -> in_ready=1 next cycle.
- Partial beat, RND_W=4 D=2 W=5: N_BEATS=3, beats 0xA,0x3,0xF -> buffer bits [9:8]=2'b11 used, upper 2 bits of third beat ignored.
- Reset asserted mid-COLLECT after 1 beat -> next cycle IDLE, out_valid=0, out_shares=0; next request needs N_BEATS fresh beats.
